// File: rtl/up_down_counter_mod.sv
// Parametrised up/down counter with runtime modulus, parallel load and wrap/saturate mode.
// Wrap pulses are registered alongside count so they line up with the wrapped value.
module up_down_counter_mod #(
    parameter int WIDTH    = 4,
    parameter int SATURATE = 0,
    parameter int RST_VAL  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] count,
    output logic             wrap_up,
    output logic             wrap_dn,
    output logic             at_max,
    output logic             at_min
);

    localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RST_VAL);
    localparam bit               SAT     = (SATURATE != 0);

    // Limit compares are done on the current value so count+1 never overflows into the result.
    logic above_max;
    logic below_max;
    logic is_zero;

    assign above_max = (count > max_val);
    assign below_max = (count < max_val);
    assign is_zero   = (count == '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            count   <= RST_CNT;
            wrap_up <= 1'b0;
            wrap_dn <= 1'b0;
        end else begin
            wrap_up <= 1'b0;
            wrap_dn <= 1'b0;
            if (load) begin
                count <= (load_val > max_val) ? max_val : load_val;
            end else if (en) begin
                if (up_down) begin
                    if (below_max) begin
                        count <= count + 1'b1;
                    end else if (SAT) begin
                        count <= max_val;
                    end else begin
                        count   <= '0;
                        wrap_up <= 1'b1;
                    end
                end else begin
                    // A count stranded above a lowered limit is pulled back without a pulse.
                    if (above_max) begin
                        count <= max_val;
                    end else if (!is_zero) begin
                        count <= count - 1'b1;
                    end else if (!SAT) begin
                        count   <= max_val;
                        wrap_dn <= 1'b1;
                    end
                end
            end
        end
    end

    assign at_max = !below_max;
    assign at_min = is_zero;

endmodule

// File: tb/tb_up_down_counter_mod.sv
// Directed bench: one wrap-mode and one saturate-mode counter driven by the same stimulus.
module tb_up_down_counter_mod;

    logic       clk = 1'b0;
    logic       rst, en, up_down, load;
    logic [3:0] load_val, max_val;
    logic [3:0] w_count, s_count;
    logic       w_wrap_up, w_wrap_dn, w_at_max, w_at_min;
    logic       s_wrap_up, s_wrap_dn, s_at_max, s_at_min;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    up_down_counter_mod #(.WIDTH(4), .SATURATE(0), .RST_VAL(0)) u_w (
        .clk(clk), .rst(rst), .en(en), .up_down(up_down), .load(load),
        .load_val(load_val), .max_val(max_val), .count(w_count),
        .wrap_up(w_wrap_up), .wrap_dn(w_wrap_dn), .at_max(w_at_max), .at_min(w_at_min)
    );

    up_down_counter_mod #(.WIDTH(4), .SATURATE(1), .RST_VAL(3)) u_s (
        .clk(clk), .rst(rst), .en(en), .up_down(up_down), .load(load),
        .load_val(load_val), .max_val(max_val), .count(s_count),
        .wrap_up(s_wrap_up), .wrap_dn(s_wrap_dn), .at_max(s_at_max), .at_min(s_at_min)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks wrap-mode count and pulses (up, dn).
    task automatic chk_w(input string tag, input int c, input bit pu, input bit pd);
        chk({tag, " w.count"}, 32'(w_count), 32'(c));
        chk({tag, " w.wrap_up"}, 32'(w_wrap_up), 32'(pu));
        chk({tag, " w.wrap_dn"}, 32'(w_wrap_dn), 32'(pd));
    endtask

    // Checks saturate-mode count; its pulses must stay low always.
    task automatic chk_s(input string tag, input int c);
        chk({tag, " s.count"}, 32'(s_count), 32'(c));
        chk({tag, " s.wrap_up"}, 32'(s_wrap_up), 32'd0);
        chk({tag, " s.wrap_dn"}, 32'(s_wrap_dn), 32'd0);
    endtask

    int b_w[12]  = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int b_s[12]  = '{4, 5, 6, 7, 8, 9, 9, 9, 9, 9, 9, 9};
    int c_w[6]   = '{1, 0, 9, 8, 9, 0};
    int c_s[6]   = '{8, 7, 6, 5, 6, 7};
    int du_w[8]  = '{1, 2, 3, 4, 5, 0, 1, 2};
    int du_s[8]  = '{1, 2, 3, 4, 5, 5, 5, 5};
    int dd_w[8]  = '{1, 0, 5, 4, 3, 2, 1, 0};
    int dd_s[8]  = '{4, 3, 2, 1, 0, 0, 0, 0};

    initial begin
        #1;
        rst = 1'b0; en = 1'b1; up_down = 1'b1; load = 1'b0;
        load_val = 4'd0; max_val = 4'd9;

        // Reset with en high: counting is suppressed
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_w("rst", 0, 1'b0, 1'b0);
            chk_s("rst", 3);
            chk("rst w.at_min", 32'(w_at_min), 32'd1);
        end
        rst = 1'b1; en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_w("hold", 0, 1'b0, 1'b0);
            chk_s("hold", 3);
            chk("hold w.at_min", 32'(w_at_min), 32'd1);
            chk("hold s.at_min", 32'(s_at_min), 32'd0);
        end

        // Up count through max_val=9
        en = 1'b1; up_down = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk_w("up", b_w[i], (i == 9), 1'b0);
            chk_s("up", b_s[i]);
            chk("up w.at_max", 32'(w_at_max), 32'(b_w[i] == 9));
            chk("up s.at_max", 32'(s_at_max), 32'(b_s[i] == 9));
        end

        // Down through zero then reverse
        up_down = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) up_down = 1'b1;
            tick();
            chk_w("dnup", c_w[i], (i == 5), (i == 2));
            chk_s("dnup", c_s[i]);
        end

        // max_val=5, start both from 0 via load
        max_val = 4'd5; load = 1'b1; load_val = 4'd0;
        tick();
        chk_w("ld0", 0, 1'b0, 1'b0);
        chk_s("ld0", 0);
        load = 1'b0; up_down = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_w("m5up", du_w[i], (i == 5), 1'b0);
            chk_s("m5up", du_s[i]);
        end
        up_down = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_w("m5dn", dd_w[i], 1'b0, (i == 2));
            chk_s("m5dn", dd_s[i]);
        end

        // Load beats en; load_val clamps to max_val
        max_val = 4'd9; load = 1'b1; load_val = 4'd7; en = 1'b1; up_down = 1'b1;
        tick();
        chk_w("ld7", 7, 1'b0, 1'b0);
        chk_s("ld7", 7);
        load_val = 4'd14;
        tick();
        chk_w("ld14", 9, 1'b0, 1'b0);
        chk_s("ld14", 9);

        // Lowered limit, down step: pulled back to max_val
        load_val = 4'd8;
        tick();
        chk_w("ld8a", 8, 1'b0, 1'b0);
        load = 1'b0; max_val = 4'd4; up_down = 1'b0;
        tick();
        chk_w("lowdn", 4, 1'b0, 1'b0);
        chk_s("lowdn", 4);

        // Lowered limit, up step
        max_val = 4'd9; load = 1'b1;
        tick();
        chk_s("ld8b", 8);
        load = 1'b0; max_val = 4'd4; up_down = 1'b1;
        tick();
        chk_w("lowup", 0, 1'b1, 1'b0);
        chk_s("lowup", 4);
        chk("lowup s.at_max", 32'(s_at_max), 32'd1);

        // Reset right after a wrap, en still high
        rst = 1'b0;
        tick();
        chk_w("rstmid", 0, 1'b0, 1'b0);
        chk_s("rstmid", 3);
        rst = 1'b1;

        // max_val=0: count pinned at 0, wrap mode pulses every step
        max_val = 4'd0; load = 1'b1; load_val = 4'd0;
        tick();
        load = 1'b0; up_down = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_w("m0up", 0, 1'b1, 1'b0);
            chk_s("m0up", 0);
        end
        up_down = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_w("m0dn", 0, 1'b0, 1'b1);
            chk_s("m0dn", 0);
        end
        en = 1'b0;
        tick();
        chk_w("m0hold", 0, 1'b0, 1'b0);

        // Full range: natural binary wrap 15 -> 0
        max_val = 4'd15; load = 1'b1; load_val = 4'd15;
        tick();
        chk("full at_max", 32'(w_at_max), 32'd1);
        load = 1'b0; en = 1'b1; up_down = 1'b1;
        tick();
        chk_w("full", 0, 1'b1, 1'b0);
        chk_s("full", 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/up_down_counter_mod.md
Name: up_down_counter_mod

Overview:
- Parametrised successor to the fixed 4-bit up/down counter.
- Generalises the width and adds a runtime modulus (max_val), count enable, synchronous parallel load, and a wrap or saturate mode.
- Adds registered wrap/underflow event pulses and limit flags.
- Used as a general event/position counter in the datapath and as a timebase divider when wrap pulses are chained to the next stage's en.

Parameters:
- WIDTH, 4: counter width in bits; legal range 2..32.
- SATURATE, 0: 0 = wrap at limits; 1 = hold at limits.
- RST_VAL, 0: count value loaded on reset; must be <= 2^WIDTH-1.

Ports:
- clk  input  1  rising-edge clock; sole clock domain.
- rst  input  1  synchronous active-low reset, sampled on the rising clk edge.
- en  input  1  count enable; no step when low.
- up_down  input  1  1 = count up, 0 = count down; sampled only when en=1.
- load  input  1  synchronous parallel load strobe.
- load_val  input  WIDTH  value loaded when load=1.
- max_val  input  WIDTH  inclusive upper limit, i.e. modulus minus 1; treated as quasi-static.
- count  output  WIDTH  registered counter value.
- wrap_up  output  1  registered one-cycle pulse: an up step crossed max_val. Asserted in wrap mode only.
- wrap_dn  output  1  registered one-cycle pulse: a down step crossed 0. Asserted in wrap mode only.
- at_max  output  1  combinational, count >= max_val.
- at_min  output  1  combinational, count == 0.

Behaviour:
- All state updates occur on the rising clk edge.
- Priority: rst low > load > en > hold.
- Reset (rst=0 at edge):
  - count = RST_VAL; wrap_up = 0; wrap_dn = 0.
  - Reset asserted mid-count aborts immediately; load and en are ignored in that cycle.
- Load (rst=1, load=1):
  - count = min(load_val, max_val).
  - wrap pulses = 0.
  - en and up_down are ignored in that cycle.
- Up step (en=1, up_down=1, load=0):
  - If count < max_val: count = count+1.
  - Else, wrap mode: count = 0 and wrap_up = 1 for exactly that cycle.
  - Else, saturate mode: count = max_val and no pulse. This also corrects a count above max_val after max_val was lowered.
- Down step (en=1, up_down=0, load=0):
  - If count > 0 and count <= max_val: count = count-1.
  - If count > max_val: count = max_val in both modes, no pulse.
  - If count == 0, wrap mode: count = max_val and wrap_dn = 1.
  - If count == 0, saturate mode: count stays 0, no pulse.
- Hold (en=0, load=0): count unchanged; wrap_up = wrap_dn = 0.
- Pulse timing:
  - wrap_up and wrap_dn go high in the same cycle count shows the wrapped value.
  - They are never high together.
  - They are high for one cycle per wrap event. Consecutive wraps, e.g. max_val=0 with en held high, give a pulse every cycle.
- max_val = 0:
  - count is held at 0.
  - Wrap mode: every enabled step pulses the wrap output for the current direction.
  - Saturate mode: no pulses.
- max_val = 2^WIDTH-1: natural binary wrap.
- Arithmetic:
  - All unsigned, WIDTH bits.
  - No intermediate overflow is permitted to alter the result; compare before incrementing.
- Latency:
  - count reflects inputs sampled at edge N immediately after edge N, a 1-cycle register.
  - at_max and at_min follow count combinationally.

Test Plan:
- Reset and hold, WIDTH=4, SATURATE=0, RST_VAL=0:
  - Stimulus: rst=0 for 2 edges with en=1, then rst=1, en=0 for 3 edges.
  - Required: count=0, at_min=1, no pulses throughout.
- Up wrap, max_val=9:
  - Stimulus: en=1, up_down=1 for 12 edges from 0.
  - Required: count 1..9, then 0, 1, 2; wrap_up=1 only in the cycle count=0 after 9.
  - Required: at_max=1 only while count=9.
- Down wrap then direction change, max_val=9:
  - Stimulus: from 2, count down 4 edges, then up_down=1 for 2 edges.
  - Required: count 1, 0, 9, 8, then 9, 0.
  - Required: wrap_dn pulses once at 0→9; wrap_up pulses once at 9→0.
- Saturate mode, SATURATE=1, max_val=5:
  - Stimulus: count up 8 edges from 0, then down 8 edges.
  - Required: count stops at 5, then stops at 0.
  - Required: wrap_up and wrap_dn stay 0 throughout.
- Load priority and clamp, max_val=9:
  - Stimulus: load=1, load_val=7, en=1 at the same edge.
  - Required: count=7, no step that cycle.
  - Stimulus: load_val=14.
  - Required: count=9.
- Reset mid-operation and lowered limit:
  - Stimulus: count at 8 with max_val=9; drop max_val to 4; step up.
  - Required: wrap mode gives count=0 with wrap_up=1; saturate mode gives count=4.
  - Stimulus: then assert rst=0 while en=1.
  - Required: count=RST_VAL, pulses 0.
